// File: rtl/core_pkg.sv
// core_pkg: shared rv32 pipeline types and fetch-side bus structs and reset/trap vectors.
package core_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {NEXT, ADDR, TRAP} pc_t;
    typedef struct packed {
        word_t pc;
        word_t ir;
    } fi_t;
    typedef struct packed {
        logic  valid;
        word_t addr;
    } imem_req_t;
    typedef struct packed {
        logic  valid;
        word_t data;
    } imem_rsp_t;
    localparam word_t CODE_BASE = 32'h0000_0000;
    localparam word_t KERN_BASE = 32'h0000_0200;
    localparam word_t RESET_PC  = CODE_BASE;
    localparam word_t TRAP_PC   = KERN_BASE;
endpackage

// File: rtl/fetch_stage_buffer.sv
// fetch_buffer: DEPTH-entry ring pairing each issued PC with its returned word.
// Entries are reserved at issue, filled in order by responses and popped by decode.
module fetch_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       alloc,
    input  word_t                      alloc_pc,
    input  logic                       fill,
    input  word_t                      fill_ir,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] used,
    output logic [$clog2(DEPTH+1)-1:0] filled,
    output fi_t                        head
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    fi_t mem [DEPTH];
    logic [AW-1:0] alloc_ptr, fill_ptr, head_ptr;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            used      <= '0;
            filled    <= '0;
        end else begin
            if (alloc) alloc_ptr <= inc(alloc_ptr);
            if (fill) fill_ptr <= inc(fill_ptr);
            if (pop) head_ptr <= inc(head_ptr);
            used   <= used + CW'(alloc) - CW'(pop);
            filled <= filled + CW'(fill) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (alloc) mem[alloc_ptr].pc <= alloc_pc;
        if (fill) mem[fill_ptr].ir <= fill_ir;
    end
    assign head = filled != '0 ? mem[head_ptr] : '0;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues word reads, and hands {pc, ir} pairs to decode.
// Redirects flush the buffer and count still-unanswered requests so their words are dropped.
module fetch_stage
    import core_pkg::*;
#(
    parameter word_t RESET_PC = core_pkg::RESET_PC,
    parameter word_t TRAP_PC  = core_pkg::TRAP_PC,
    parameter int    DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pc_t         pc_sel,
    input  logic [31:0] pc_addr,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        fi_valid,
    input  logic        fi_ready,
    output fi_t         fi_data
);
    localparam int CW = $clog2(DEPTH + 1);
    word_t pc;
    logic [CW-1:0] used, filled, discard;
    imem_req_t req;
    imem_rsp_t rsp;
    logic redirect, alloc, fill, pop;
    assign rsp = {imem_rsp_valid, imem_rsp_data};
    // Discarded-but-outstanding requests still occupy bus slots, so they count against DEPTH.
    always_comb begin
        redirect  = pc_sel != NEXT;
        req.valid = rst_n && !redirect && (int'(used) + int'(discard) < DEPTH);
        req.addr  = pc & 32'hFFFF_FFFC;
        alloc     = req.valid && imem_req_ready;
        fill      = rsp.valid && discard == '0 && !redirect;
        pop       = fi_valid && fi_ready && !redirect;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            discard <= '0;
        end else if (redirect) begin
            pc      <= pc_sel == ADDR ? pc_addr & 32'hFFFF_FFFC : TRAP_PC;
            discard <= discard + used - filled - CW'(rsp.valid);
        end else begin
            if (alloc) pc <= pc + 32'd4;
            if (rsp.valid && discard != '0) discard <= discard - CW'(1);
        end
    end
    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .alloc    (alloc),
        .alloc_pc (req.addr),
        .fill     (fill),
        .fill_ir  (rsp.data),
        .pop      (pop),
        .used     (used),
        .filled   (filled),
        .head     (fi_data)
    );
    assign fi_valid       = filled != '0;
    assign imem_req_valid = req.valid;
    assign imem_req_addr  = req.addr;
endmodule
